// File: rtl/adder_pkg.sv
// Shared chunking helpers, mode encoding and the per-stage carry/valid bundle
// used by the pipelined wide adder/subtractor.
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic vld;
        logic carry;
    } stage_ctl_t;

    // Nominal chunk width: ceil(width / stages).
    function automatic int chunk_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int chunk_lo(input int k, input int width, input int stages);
        return k * chunk_width(width, stages);
    endfunction

    // The last stage takes whatever bits remain above the full-size chunks.
    function automatic int chunk_w_of(input int k, input int width, input int stages);
        if (k == stages - 1)
            return width - (stages - 1) * chunk_width(width, stages);
        return chunk_width(width, stages);
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub: valid/ready on both sides,
// mode and carry-in travel with the operands.
interface pipelined_addsub_if #(
    parameter int WIDTH = 148
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/addsub_chunk_stage.sv
// One pipeline slice: adds chunk [LO +: CHUNK_W] with the incoming carry, registers it; one cycle.
// Holds everything while en is low; operands and lower result bits ride through unchanged.
module addsub_chunk_stage
    import adder_pkg::*;
#(
    parameter int WIDTH   = 148,
    parameter int CHUNK_W = 37,
    parameter int LO      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  stage_ctl_t       ctl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] bx_i,
    input  logic [WIDTH-1:0] r_i,
    output stage_ctl_t       ctl_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] bx_o,
    output logic [WIDTH-1:0] r_o
);

    logic [CHUNK_W:0]  part;
    logic [WIDTH-1:0]  r_nxt;

    always_comb begin
        part  = {1'b0, a_i[LO +: CHUNK_W]} + {1'b0, bx_i[LO +: CHUNK_W]}
              + {{CHUNK_W{1'b0}}, ctl_i.carry};
        r_nxt = r_i;
        r_nxt[LO +: CHUNK_W] = part[CHUNK_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_o <= '0;
            a_o   <= '0;
            bx_o  <= '0;
            r_o   <= '0;
        end else if (en) begin
            ctl_o.vld   <= ctl_i.vld;
            ctl_o.carry <= part[CHUNK_W];
            a_o         <= a_i;
            bx_o        <= bx_i;
            r_o         <= r_nxt;
        end
    end

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/sub split into STAGES carry-chained chunks; result STAGES cycles after accept.
// Full-pipeline stall: every stage holds while out_valid is high and out_ready is low.
module pipelined_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 148,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_addsub_if.slave  io
);

    stage_ctl_t       ctl_p [0:STAGES];
    logic [WIDTH-1:0] a_p   [0:STAGES];
    logic [WIDTH-1:0] bx_p  [0:STAGES];
    logic [WIDTH-1:0] r_p   [0:STAGES];
    logic             en;

    // Ready depends only on the output register, never on in_valid.
    assign io.in_ready = !io.out_valid || io.out_ready;
    assign en          = io.in_ready;

    // Subtraction is A + ~B + 1: invert B up front and force the first carry.
    assign ctl_p[0].vld   = io.in_valid;
    assign ctl_p[0].carry = (io.sub == MODE_SUB) ? 1'b1 : io.cin;
    assign a_p[0]         = io.a;
    assign bx_p[0]        = (io.sub == MODE_SUB) ? ~io.b : io.b;
    assign r_p[0]         = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO_K = chunk_lo(k, WIDTH, STAGES);
        localparam int CW_K = chunk_w_of(k, WIDTH, STAGES);

        addsub_chunk_stage #(
            .WIDTH   (WIDTH),
            .CHUNK_W (CW_K),
            .LO      (LO_K)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .ctl_i (ctl_p[k]),
            .a_i   (a_p[k]),
            .bx_i  (bx_p[k]),
            .r_i   (r_p[k]),
            .ctl_o (ctl_p[k+1]),
            .a_o   (a_p[k+1]),
            .bx_o  (bx_p[k+1]),
            .r_o   (r_p[k+1])
        );
    end

    // The last stage's carry-out is the top result bit (no-borrow flag in sub mode).
    assign io.out_valid = ctl_p[STAGES].vld;
    assign io.sum       = {ctl_p[STAGES].carry, r_p[STAGES]};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, random mixed stream with backpressure,
// mid-flight reset, and three small WIDTH=10 configurations run in lockstep.
module tb_pipelined_addsub;

    localparam int W  = 148;
    localparam int NS = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    pipelined_addsub_if #(.WIDTH(W))  m   ();
    pipelined_addsub_if #(.WIDTH(10)) s3  ();
    pipelined_addsub_if #(.WIDTH(10)) s1  ();
    pipelined_addsub_if #(.WIDTH(10)) s10 ();

    pipelined_addsub #(.WIDTH(W),  .STAGES(4))  u_dut  (.clk(clk), .rst_n(rst_n), .io(m));
    pipelined_addsub #(.WIDTH(10), .STAGES(3))  u_dut3 (.clk(clk), .rst_n(rst_n), .io(s3));
    pipelined_addsub #(.WIDTH(10), .STAGES(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .io(s1));
    pipelined_addsub #(.WIDTH(10), .STAGES(10)) u_dut10(.clk(clk), .rst_n(rst_n), .io(s10));

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W:0]   exp;
    } vec_t;

    vec_t        vecs [9];
    logic [10:0] exp_hist [NS];

    // Whole-width arithmetic: subtraction as A - B offset by 2^W.
    function automatic logic [W:0] ref148(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s, input logic c);
        if (s) return {1'b0, a} - {1'b0, b} + (149'd1 << W);
        return {1'b0, a} + {1'b0, b} + {148'd0, c};
    endfunction

    function automatic logic [10:0] ref10(input logic [9:0] a, input logic [9:0] b,
                                          input logic s, input logic c);
        if (s) return {1'b0, a} - {1'b0, b} + 11'd1024;
        return {1'b0, a} + {1'b0, b} + {10'd0, c};
    endfunction

    function automatic logic [W-1:0] rand148();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 7) == 0) r = '1;
        return r[W-1:0];
    endfunction

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             input logic c, output logic [W:0] res, output int lat);
        @(posedge clk); #1;
        m.a = a; m.b = b; m.sub = s; m.cin = c; m.in_valid = 1'b1; m.out_ready = 1'b1;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        lat = 1;
        while (!m.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = m.sum;
    endtask

    task automatic drive_small(input logic [21:0] w, input logic v);
        s3.a  = w[9:0]; s3.b  = w[19:10]; s3.sub  = w[20]; s3.cin  = w[21]; s3.in_valid  = v;
        s1.a  = w[9:0]; s1.b  = w[19:10]; s1.sub  = w[20]; s1.cin  = w[21]; s1.in_valid  = v;
        s10.a = w[9:0]; s10.b = w[19:10]; s10.sub = w[20]; s10.cin = w[21]; s10.in_valid = v;
    endtask

    task automatic check_small(input string nm, input logic v, input logic [10:0] s, input int idx);
        if (idx >= 0 && idx < NS) check(nm, {148'd0, v, s}, {148'd0, 1'b1, exp_hist[idx]});
        else                      check(nm, {159'd0, v}, 160'd0);
    endtask

    task automatic run_stream();
        logic [W:0] q[$];
        logic [W:0] held;
        bit         stalled = 0;
        bit         acc = 0;
        int         sent = 0;
        int         got = 0;
        int         cyc = 0;
        m.in_valid = 1'b0;
        while (got < 16 && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            if (!m.in_valid || acc) begin
                if (sent < 16 && $urandom_range(0, 3) != 0) begin
                    m.a = rand148(); m.b = rand148();
                    m.sub = 1'($urandom_range(0, 1)); m.cin = 1'($urandom_range(0, 1));
                    m.in_valid = 1'b1;
                end else begin
                    m.in_valid = 1'b0;
                end
            end
            m.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stalled) check("stall_hold", {10'd0, m.out_valid, m.sum}, {10'd0, 1'b1, held});
            stalled = m.out_valid && !m.out_ready;
            held    = m.sum;
            acc     = m.in_valid && m.in_ready;
            if (acc) q.push_back(ref148(m.a, m.b, m.sub, m.cin));
            if (m.out_valid && m.out_ready) begin
                got++;
                if (q.size() == 0) check("stream_extra", {11'd0, m.sum}, 160'd0 - 1);
                else               check("stream_data", {11'd0, m.sum}, {11'd0, q.pop_front()});
            end
        end
        check("stream_count", 160'(got), 160'd16);
        check("stream_left", 160'(q.size()), 160'd0);
        @(posedge clk); #1;
        m.in_valid = 1'b0; m.out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W:0]  res;
        int          lat;
        bit          seen;
        logic [21:0] w;
        logic [21:0] cw [8];
        logic [W-1:0] ones;

        ones = '1;
        vecs[0] = '{"carry_ripple", ones,        148'd0,      1'b0, 1'b1, {1'b1, 148'd0}};
        vecs[1] = '{"sub_borrow",   148'd5,      148'd7,      1'b1, 1'b0, {1'b0, ones - 148'd1}};
        vecs[2] = '{"sub_noborrow", 148'd7,      148'd5,      1'b1, 1'b0, {1'b1, 148'd2}};
        vecs[3] = '{"add_zero",     148'd0,      148'd0,      1'b0, 1'b0, 149'd0};
        vecs[4] = '{"sub_equal",    148'h1234,   148'h1234,   1'b1, 1'b1, {1'b1, 148'd0}};
        vecs[5] = '{"add_max",      ones,        ones,        1'b0, 1'b1, {1'b1, ones}};
        vecs[6] = '{"sub_0_1",      148'd0,      148'd1,      1'b1, 1'b0, {1'b0, ones}};
        vecs[7] = '{"chunk0_carry", (148'd1 << 37) - 148'd1, 148'd1, 1'b0, 1'b0, 149'd1 << 37};
        vecs[8] = '{"add_ones_nc",  ones,        148'd0,      1'b0, 1'b0, {1'b0, ones}};

        cw[0] = {1'b1, 1'b0, 10'd0,    10'd1023};
        cw[1] = {1'b1, 1'b0, 10'd1023, 10'd1023};
        cw[2] = {1'b0, 1'b1, 10'd1023, 10'd0};
        cw[3] = {1'b1, 1'b1, 10'd512,  10'd512};
        cw[4] = {1'b0, 1'b0, 10'd1,    10'd15};
        cw[5] = {1'b0, 1'b0, 10'd1,    10'd255};
        cw[6] = {1'b0, 1'b1, 10'd0,    10'd0};
        cw[7] = {1'b0, 1'b0, 10'd0,    10'd0};

        m.in_valid = 1'b0; m.a = '0; m.b = '0; m.sub = 1'b0; m.cin = 1'b0; m.out_ready = 1'b1;
        s3.out_ready = 1'b1; s1.out_ready = 1'b1; s10.out_ready = 1'b1;
        drive_small(22'd0, 1'b0);

        // Reset held with live random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            m.a = rand148(); m.b = rand148(); m.sub = 1'($urandom_range(0, 1));
            m.cin = 1'($urandom_range(0, 1)); m.in_valid = 1'b1;
            m.out_ready = 1'($urandom_range(0, 1));
            drive_small(22'($urandom), 1'b1);
            @(negedge clk);
            check("reset_out", {10'd0, m.out_valid, m.sum}, 160'd0);
            check("reset_small_vld", {157'd0, s3.out_valid, s1.out_valid, s10.out_valid}, 160'd0);
        end
        @(posedge clk); #1;
        m.in_valid = 1'b0; m.out_ready = 1'b1;
        drive_small(22'd0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", {159'd0, m.in_ready}, 160'd1);

        for (int i = 0; i < 9; i++) begin
            send_wait(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, res, lat);
            check({vecs[i].name, "_sum"}, {11'd0, res}, {11'd0, vecs[i].exp});
            check({vecs[i].name, "_lat"}, 160'(lat), 160'd4);
        end

        run_stream();

        // Reset while three beats are in flight, the oldest stalled at the output.
        m.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            m.a = rand148(); m.b = rand148(); m.sub = i[0]; m.cin = 1'b1; m.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        @(posedge clk); #1;
        check("flush_pre_valid", {159'd0, m.out_valid}, 160'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("flush_out", {10'd0, m.out_valid, m.sum}, 160'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        m.out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= m.out_valid;
        end
        check("flush_no_emit", {159'd0, seen}, 160'd0);
        w = 22'($urandom);
        send_wait({138'd0, w[9:0]}, {w, 126'd0}, 1'b0, 1'b1, res, lat);
        check("flush_first_new", {11'd0, res},
              {11'd0, ref148({138'd0, w[9:0]}, {w, 126'd0}, 1'b0, 1'b1)});
        check("flush_first_lat", 160'(lat), 160'd4);

        // Three small configurations fed the same stream, always ready.
        @(posedge clk); #1;
        w = cw[0];
        exp_hist[0] = ref10(w[9:0], w[19:10], w[20], w[21]);
        drive_small(w, 1'b1);
        for (int j = 1; j < NS + 12; j++) begin
            @(posedge clk); #1;
            check_small("w10_s3",  s3.out_valid,  s3.sum,  j - 3);
            check_small("w10_s1",  s1.out_valid,  s1.sum,  j - 1);
            check_small("w10_s10", s10.out_valid, s10.sum, j - 10);
            if (j < NS) begin
                w = (j < 8) ? cw[j] : 22'($urandom);
                exp_hist[j] = ref10(w[9:0], w[19:10], w[20], w[21]);
                drive_small(w, 1'b1);
            end else begin
                drive_small(22'd0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
